// File: rtl/dense_layer_engine.sv
// Lane-parallel int8 dense layer: LANES neurons per group, bias + int8 MAC into ACC_W, rounding requant to int8.
// Per group: BIAS, LOAD, N-1 MAC, DRAIN, then one EMIT cycle per active lane; only EMIT stalls on out_ready.
module dense_layer_engine #(
    parameter int MAX_IN  = 256,
    parameter int MAX_OUT = 64,
    parameter int LANES   = 4,
    parameter int ACC_W   = 32
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic [$clog2(MAX_IN+1)-1:0]             input_size,
    input  logic [$clog2(MAX_OUT+1)-1:0]            output_size,
    input  logic [4:0]                              out_shift,
    input  logic                                    relu_en,
    output logic [$clog2(MAX_IN)-1:0]               tensor_ram_addr,
    output logic                                    tensor_ram_re,
    input  logic [7:0]                              tensor_ram_dout,
    output logic [$clog2(MAX_IN*MAX_OUT/LANES)-1:0] weight_rom_addr,
    output logic                                    weight_rom_re,
    input  logic [8*LANES-1:0]                      weight_rom_dout,
    output logic [$clog2(MAX_OUT/LANES)-1:0]        bias_rom_addr,
    output logic                                    bias_rom_re,
    input  logic [ACC_W*LANES-1:0]                  bias_rom_dout,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [7:0]                              out_data,
    output logic [$clog2(MAX_OUT)-1:0]              out_idx,
    output logic                                    busy,
    output logic                                    done
);

    localparam int NW    = $clog2(MAX_IN + 1);
    localparam int MW    = $clog2(MAX_OUT + 1);
    localparam int TA_W  = $clog2(MAX_IN);
    localparam int WA_W  = $clog2(MAX_IN * MAX_OUT / LANES);
    localparam int BA_W  = $clog2(MAX_OUT / LANES);
    localparam int IDX_W = $clog2(MAX_OUT);
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic signed [ACC_W:0] Q_MAX = 127;
    localparam logic signed [ACC_W:0] Q_MIN = -128;

    typedef enum logic [2:0] {
        S_IDLE, S_BIAS, S_LOAD, S_MAC, S_DRAIN, S_EMIT, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [NW-1:0]     n_q, n_d, i_q, i_d;
    logic [MW-1:0]     m_q, m_d;
    logic [4:0]        shift_q, shift_d;
    logic              relu_q, relu_d;
    logic [BA_W-1:0]   g_q, g_d;
    logic [IDX_W-1:0]  gbase_q, gbase_d;
    logic [WA_W-1:0]   wbase_q, wbase_d;
    logic [LW-1:0]     lane_q, lane_d;
    logic [ACC_W-1:0]  acc_q [LANES];
    logic [ACC_W-1:0]  acc_d [LANES];

    logic signed [15:0] prod [LANES];
    logic [NW-1:0]      n_clamp;
    logic [MW-1:0]      m_clamp;
    logic [MW:0]        next_neuron;
    logic               last_lane, last_group;

    // Rounding shift is done one bit wider than the accumulator so the bias add cannot wrap.
    function automatic logic [7:0] requant(input logic [ACC_W-1:0] acc,
                                           input logic [4:0]       sh,
                                           input logic             relu);
        logic signed [ACC_W:0] ext;
        logic signed [ACC_W:0] rnd;
        logic signed [ACC_W:0] r;
        ext = {acc[ACC_W-1], acc};
        rnd = (sh != 5'd0) ? ((ACC_W+1)'(1) << (sh - 5'd1)) : '0;
        r   = (ext + rnd) >>> sh;
        if (relu && r[ACC_W]) r = '0;
        if (r > Q_MAX)      return 8'h7F;
        else if (r < Q_MIN) return 8'h80;
        else                return r[7:0];
    endfunction

    assign n_clamp = (input_size > NW'(MAX_IN))   ? NW'(MAX_IN)  : input_size;
    assign m_clamp = (output_size > MW'(MAX_OUT)) ? MW'(MAX_OUT) : output_size;

    assign next_neuron = (MW+1)'(gbase_q) + (MW+1)'(lane_q) + (MW+1)'(1);
    assign last_lane   = (lane_q == LW'(LANES - 1)) || (next_neuron >= (MW+1)'(m_q));
    assign last_group  = ((MW+1)'(gbase_q) + (MW+1)'(LANES)) >= (MW+1)'(m_q);

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            prod[k] = $signed(tensor_ram_dout) * $signed(weight_rom_dout[8*k +: 8]);
        end
    end

    assign busy = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        m_d     = m_q;
        shift_d = shift_q;
        relu_d  = relu_q;
        g_d     = g_q;
        gbase_d = gbase_q;
        wbase_d = wbase_q;
        i_d     = i_q;
        lane_d  = lane_q;
        for (int k = 0; k < LANES; k++) acc_d[k] = acc_q[k];
        tensor_ram_re   = 1'b0;
        tensor_ram_addr = '0;
        weight_rom_re   = 1'b0;
        weight_rom_addr = '0;
        bias_rom_re     = 1'b0;
        bias_rom_addr   = '0;
        out_valid       = 1'b0;
        out_data        = '0;
        out_idx         = '0;
        done            = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d     = n_clamp;
                    m_d     = m_clamp;
                    shift_d = out_shift;
                    relu_d  = relu_en;
                    g_d     = '0;
                    gbase_d = '0;
                    wbase_d = '0;
                    i_d     = '0;
                    lane_d  = '0;
                    state_d = (m_clamp == '0) ? S_DONE : S_BIAS;
                end
            end
            S_BIAS: begin
                bias_rom_re   = 1'b1;
                bias_rom_addr = g_q;
                state_d       = S_LOAD;
            end
            S_LOAD: begin
                for (int k = 0; k < LANES; k++) acc_d[k] = bias_rom_dout[ACC_W*k +: ACC_W];
                i_d    = NW'(1);
                lane_d = '0;
                if (n_q == '0) begin
                    state_d = S_EMIT;
                end else begin
                    tensor_ram_re   = 1'b1;
                    weight_rom_re   = 1'b1;
                    weight_rom_addr = wbase_q;
                    state_d         = (n_q == NW'(1)) ? S_DRAIN : S_MAC;
                end
            end
            S_MAC: begin
                // Issue read i while folding in the product of read i-1.
                tensor_ram_re   = 1'b1;
                tensor_ram_addr = i_q[TA_W-1:0];
                weight_rom_re   = 1'b1;
                weight_rom_addr = wbase_q + WA_W'(i_q);
                for (int k = 0; k < LANES; k++)
                    acc_d[k] = acc_q[k] + {{(ACC_W-16){prod[k][15]}}, prod[k]};
                i_d = i_q + NW'(1);
                if (i_q == n_q - NW'(1)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                for (int k = 0; k < LANES; k++)
                    acc_d[k] = acc_q[k] + {{(ACC_W-16){prod[k][15]}}, prod[k]};
                state_d = S_EMIT;
            end
            S_EMIT: begin
                out_valid = 1'b1;
                out_data  = requant(acc_q[lane_q], shift_q, relu_q);
                out_idx   = gbase_q + IDX_W'(lane_q);
                if (out_ready) begin
                    lane_d = '0;
                    if (!last_lane) begin
                        lane_d = lane_q + LW'(1);
                    end else if (last_group) begin
                        state_d = S_DONE;
                    end else begin
                        g_d     = g_q + BA_W'(1);
                        gbase_d = gbase_q + IDX_W'(LANES);
                        wbase_d = wbase_q + WA_W'(n_q);
                        state_d = S_BIAS;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            m_q     <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            g_q     <= '0;
            gbase_q <= '0;
            wbase_q <= '0;
            i_q     <= '0;
            lane_q  <= '0;
            for (int k = 0; k < LANES; k++) acc_q[k] <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            m_q     <= m_d;
            shift_q <= shift_d;
            relu_q  <= relu_d;
            g_q     <= g_d;
            gbase_q <= gbase_d;
            wbase_q <= wbase_d;
            i_q     <= i_d;
            lane_q  <= lane_d;
            for (int k = 0; k < LANES; k++) acc_q[k] <= acc_d[k];
        end
    end

endmodule

// File: tb/tb_dense_layer_engine.sv
// Directed bench for dense_layer_engine: hand-computed layers, edge sizes, backpressure and mid-run reset.
module tb_dense_layer_engine;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [8:0]   input_size;
    logic [6:0]   output_size;
    logic [4:0]   out_shift;
    logic         relu_en;
    logic [7:0]   tensor_ram_addr;
    logic         tensor_ram_re;
    logic [7:0]   tensor_ram_dout;
    logic [11:0]  weight_rom_addr;
    logic         weight_rom_re;
    logic [31:0]  weight_rom_dout;
    logic [3:0]   bias_rom_addr;
    logic         bias_rom_re;
    logic [127:0] bias_rom_dout;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic [5:0]   out_idx;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    int t_cnt  = 0;
    int rd_cnt = 0;

    logic [7:0]   tmem [256];
    logic [31:0]  wmem [4096];
    logic [127:0] bmem [16];
    logic [7:0]   got_data [16];
    logic [5:0]   got_idx  [16];

    dense_layer_engine #(.MAX_IN(256), .MAX_OUT(64), .LANES(4), .ACC_W(32)) dut (
        .clk(clk), .reset(reset), .start(start),
        .input_size(input_size), .output_size(output_size),
        .out_shift(out_shift), .relu_en(relu_en),
        .tensor_ram_addr(tensor_ram_addr), .tensor_ram_re(tensor_ram_re), .tensor_ram_dout(tensor_ram_dout),
        .weight_rom_addr(weight_rom_addr), .weight_rom_re(weight_rom_re), .weight_rom_dout(weight_rom_dout),
        .bias_rom_addr(bias_rom_addr), .bias_rom_re(bias_rom_re), .bias_rom_dout(bias_rom_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tensor_ram_re) tensor_ram_dout <= tmem[tensor_ram_addr];
        if (weight_rom_re) weight_rom_dout <= wmem[weight_rom_addr];
        if (bias_rom_re)   bias_rom_dout   <= bmem[bias_rom_addr];
        if (tensor_ram_re) t_cnt  <= t_cnt + 1;
        if (tensor_ram_re || weight_rom_re || bias_rom_re) rd_cnt <= rd_cnt + 1;
    end

    task automatic clear_mem;
        for (int a = 0; a < 256; a++)  tmem[a] = 8'h00;
        for (int a = 0; a < 4096; a++) wmem[a] = 32'h0;
        for (int a = 0; a < 16; a++)   bmem[a] = 128'h0;
    endtask

    task automatic load_basic(input logic signed [31:0] bias2);
        clear_mem;
        tmem[0] = 8'd1; tmem[1] = 8'd2; tmem[2] = 8'd3;
        for (int a = 0; a < 8; a++) wmem[a] = 32'h01010101;
        bmem[0] = {32'd100, bias2, 32'd10, 32'd0};
    endtask

    // Accepts start on the next rising edge, then scrambles the config to prove it was latched.
    task automatic start_layer(input logic [8:0] n, input logic [6:0] m,
                               input logic [4:0] sh, input logic r);
        @(negedge clk);
        input_size = n; output_size = m; out_shift = sh; relu_en = r; start = 1'b1;
        @(negedge clk);
        start = 1'b0; input_size = 9'h1FF; output_size = 7'h7F; out_shift = 5'd31; relu_en = ~r;
    endtask

    // Gathers handshaked outputs until done; lat counts edges from the start edge, -1 on timeout.
    task automatic run_collect(input int max_cyc, output int nout, output int lat);
        nout = 0;
        lat  = -1;
        for (int c = 1; c <= max_cyc; c++) begin
            if (out_valid && out_ready && nout < 16) begin
                got_data[nout] = out_data;
                got_idx[nout]  = out_idx;
                nout++;
            end
            if (done) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; out_ready = 1'b1;
        input_size = '0; output_size = '0; out_shift = '0; relu_en = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: busy=%b done=%b want 0 0", busy, done); end
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_idx !== 6'd0) begin errors++; $display("FAIL reset_out: valid=%b data=%h idx=%0d want 0 00 0", out_valid, out_data, out_idx); end
        checks++; if (tensor_ram_re !== 1'b0 || weight_rom_re !== 1'b0 || bias_rom_re !== 1'b0) begin errors++; $display("FAIL reset_re: t=%b w=%b b=%b want 0", tensor_ram_re, weight_rom_re, bias_rom_re); end
        checks++; if (tensor_ram_addr !== 8'd0 || weight_rom_addr !== 12'd0 || bias_rom_addr !== 4'd0) begin errors++; $display("FAIL reset_addr: t=%0d w=%0d b=%0d want 0", tensor_ram_addr, weight_rom_addr, bias_rom_addr); end
        reset = 1'b0;
    endtask

    task automatic check_basic_run(input string tag, input logic relu, input logic [7:0] lane2);
        int nout, lat, t0;
        logic [7:0] exp_d [4];
        exp_d = '{8'd6, 8'd16, lane2, 8'd106};
        out_ready = 1'b1;
        t0 = t_cnt;
        start_layer(9'd3, 7'd4, 5'd0, relu);
        run_collect(100, nout, lat);
        checks++; if (lat !== 10) begin errors++; $display("FAIL %s_latency: got %0d want 10", tag, lat); end
        checks++; if (nout !== 4) begin errors++; $display("FAIL %s_count: got %0d want 4", tag, nout); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got_data[k] !== exp_d[k] || got_idx[k] !== 6'(k)) begin
                errors++;
                $display("FAIL %s_out%0d: data=%0d idx=%0d want data=%0d idx=%0d", tag, k,
                         $signed(got_data[k]), got_idx[k], $signed(exp_d[k]), k);
            end
        end
        checks++; if (t_cnt - t0 !== 3) begin errors++; $display("FAIL %s_reads: got %0d tensor reads want 3", tag, t_cnt - t0); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_after_done: got %b want 0", tag, busy); end
    endtask

    task automatic test_basic;
        load_basic(-32'sd10);
        check_basic_run("basic", 1'b0, 8'hFC);
    endtask

    task automatic test_relu;
        load_basic(-32'sd20);
        check_basic_run("relu", 1'b1, 8'h00);
    endtask

    task automatic test_saturation;
        int nout, lat;
        logic [7:0] tin  [3];
        logic [4:0] sh   [3];
        logic [7:0] want [3];
        tin  = '{8'd127, 8'd127, 8'h80};
        sh   = '{5'd0, 5'd7, 5'd0};
        want = '{8'd127, 8'd126, 8'h80};
        clear_mem;
        wmem[0] = 32'h0000007F;
        out_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tmem[0] = tin[t];
            start_layer(9'd1, 7'd1, sh[t], 1'b0);
            run_collect(50, nout, lat);
            checks++; if (lat !== 5) begin errors++; $display("FAIL sat%0d_latency: got %0d want 5", t, lat); end
            checks++;
            if (nout !== 1 || got_data[0] !== want[t] || got_idx[0] !== 6'd0) begin
                errors++;
                $display("FAIL sat%0d_out: n=%0d data=%0d idx=%0d want n=1 data=%0d idx=0", t, nout,
                         $signed(got_data[0]), got_idx[0], $signed(want[t]));
            end
        end
    endtask

    task automatic test_back_to_back_groups;
        int nout;
        logic pend, seen_done, rdy;
        logic [7:0] hd;
        logic [5:0] hi;
        logic [7:0] want [6];
        want = '{8'd1, 8'd14, 8'd27, 8'd40, 8'd53, 8'd66};
        clear_mem;
        tmem[0] = 8'd3; tmem[1] = 8'hFE;
        wmem[0] = 32'h04030201; wmem[1] = 32'h01010101;
        wmem[2] = 32'h08070605; wmem[3] = 32'h01010101;
        bmem[0] = {32'd30, 32'd20, 32'd10, 32'd0};
        bmem[1] = {32'd70, 32'd60, 32'd50, 32'd40};
        out_ready = 1'b0;
        start_layer(9'd2, 7'd6, 5'd0, 1'b0);
        nout = 0; pend = 1'b0; seen_done = 1'b0; hd = '0; hi = '0;
        for (int c = 0; c < 400 && !seen_done; c++) begin
            if (done) begin
                seen_done = 1'b1;
            end else begin
                if (pend) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== hd || out_idx !== hi) begin
                        errors++;
                        $display("FAIL hold_stable: valid=%b data=%0d idx=%0d want 1 %0d %0d",
                                 out_valid, $signed(out_data), out_idx, $signed(hd), hi);
                    end
                end
                rdy = pend ? 1'($urandom_range(0, 1)) : 1'b0;
                out_ready = rdy;
                if (out_valid && rdy) begin
                    if (nout < 16) begin got_data[nout] = out_data; got_idx[nout] = out_idx; end
                    nout++;
                    pend = 1'b0;
                end else if (out_valid) begin
                    pend = 1'b1; hd = out_data; hi = out_idx;
                end
                @(negedge clk);
            end
        end
        out_ready = 1'b1;
        checks++; if (seen_done !== 1'b1) begin errors++; $display("FAIL groups_done: got %b want 1", seen_done); end
        checks++; if (nout !== 6) begin errors++; $display("FAIL groups_count: got %0d want 6", nout); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (got_data[k] !== want[k] || got_idx[k] !== 6'(k)) begin
                errors++;
                $display("FAIL groups_out%0d: data=%0d idx=%0d want data=%0d idx=%0d", k,
                         $signed(got_data[k]), got_idx[k], $signed(want[k]), k);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_edge_sizes;
        int nout, lat, t0, r0;
        logic [7:0] want [4];
        want = '{8'd127, 8'h80, 8'd5, 8'hF9};
        clear_mem;
        bmem[0] = {-32'sd7, 32'd5, -32'sd300, 32'd200};
        out_ready = 1'b1;
        t0 = t_cnt;
        start_layer(9'd0, 7'd4, 5'd0, 1'b0);
        run_collect(50, nout, lat);
        checks++; if (lat !== 7) begin errors++; $display("FAIL n0_latency: got %0d want 7", lat); end
        checks++; if (nout !== 4) begin errors++; $display("FAIL n0_count: got %0d want 4", nout); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got_data[k] !== want[k] || got_idx[k] !== 6'(k)) begin
                errors++;
                $display("FAIL n0_out%0d: data=%0d idx=%0d want data=%0d idx=%0d", k,
                         $signed(got_data[k]), got_idx[k], $signed(want[k]), k);
            end
        end
        checks++; if (t_cnt - t0 !== 0) begin errors++; $display("FAIL n0_reads: got %0d tensor reads want 0", t_cnt - t0); end
        @(negedge clk);
        r0 = rd_cnt;
        start_layer(9'd3, 7'd0, 5'd0, 1'b0);
        run_collect(20, nout, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL m0_latency: got %0d want 1", lat); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL m0_busy_in_done: got %b want 1", busy); end
        checks++; if (nout !== 0) begin errors++; $display("FAIL m0_count: got %0d want 0", nout); end
        @(negedge clk);
        checks++; if (rd_cnt - r0 !== 0) begin errors++; $display("FAIL m0_reads: got %0d want 0", rd_cnt - r0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL m0_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_mac;
        load_basic(-32'sd10);
        for (int a = 3; a < 8; a++) tmem[a] = 8'd9;
        out_ready = 1'b1;
        start_layer(9'd8, 7'd4, 5'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++; if (tensor_ram_re !== 1'b1) begin errors++; $display("FAIL mid_in_mac: tensor_ram_re=%b want 1", tensor_ram_re); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_idle: busy=%b valid=%b want 0 0", busy, out_valid); end
        checks++; if (tensor_ram_re !== 1'b0 || weight_rom_addr !== 12'd0) begin errors++; $display("FAIL mid_reset_bus: re=%b waddr=%0d want 0 0", tensor_ram_re, weight_rom_addr); end
        check_basic_run("rerun", 1'b0, 8'hFC);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_relu;
        test_saturation;
        test_back_to_back_groups;
        test_edge_sizes;
        test_reset_mid_mac;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dense_layer_engine.md
# dense_layer_engine

Parametrised, lane-parallel successor to the single-MAC dense layer. It computes `LANES` output neurons at once: signed int8 inputs times int8 weights, accumulated onto int32 biases. Each result is requantized with a rounding right-shift, optional ReLU and int8 saturation, then streamed out over a valid/ready port. It sits between tensor RAM and the weight/bias ROMs on the input side, and the activation write-back path on the output side.

## Interface
Parameters:
- `MAX_IN`, 256, maximum input vector length.
- `MAX_OUT`, 64, maximum output vector length; must be a multiple of `LANES`.
- `LANES`, 4, number of parallel MAC lanes (power of two, 1..16).
- `ACC_W`, 32, accumulator and bias width.

Ports:
- `clk` in 1: clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: start request; sampled only in IDLE.
- `input_size` in $clog2(MAX_IN+1): N, latched at start.
- `output_size` in $clog2(MAX_OUT+1): M, latched at start.
- `out_shift` in 5: requant right shift, latched at start.
- `relu_en` in 1: clamp negative results to 0, latched at start.
- `tensor_ram_addr` out $clog2(MAX_IN); `tensor_ram_re` out 1; `tensor_ram_dout` in 8: signed input, 1-cycle read latency.
- `weight_rom_addr` out $clog2(MAX_IN*MAX_OUT/LANES); `weight_rom_re` out 1; `weight_rom_dout` in 8*LANES, 1-cycle latency.
- `bias_rom_addr` out $clog2(MAX_OUT/LANES); `bias_rom_re` out 1; `bias_rom_dout` in ACC_W*LANES, 1-cycle latency.
- `out_valid` out 1; `out_ready` in 1; `out_data` out 8: signed int8 result; `out_idx` out $clog2(MAX_OUT): neuron index.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse when the layer finishes.

## Operation
- Outputs are processed in groups. Group g covers neurons g*LANES .. g*LANES+LANES-1. There are G = ceil(M/LANES) groups.
- Lane k of a group is active when g*LANES+k < M.
- Weight word address is g*N + i. Byte k of that word, `[8k+7:8k]`, is the weight for input i and neuron g*LANES+k.
- Bias word address is g. Slice k of that word, `[ACC_W*k +: ACC_W]`, is the bias for lane k.
- Inputs greater than the maximum are clamped: N = min(input_size, MAX_IN), M = min(output_size, MAX_OUT).
- States and transitions:
  - IDLE: `start` goes to BIAS, or directly to DONE if M==0.
  - BIAS: asserts `bias_rom_re`; goes to LOAD.
  - LOAD: acc[k] <= bias slice k. Also issues the read for i=0 if N>0. Goes to MAC if N>0, else to EMIT.
  - MAC: issues reads for i=1..N-1, one per cycle, while accumulating returned data. Goes to DRAIN after i=N-1 is issued (immediately if N==1).
  - DRAIN: accumulates the last product; goes to EMIT.
  - EMIT: presents active lanes in ascending order. The next lane or next group is taken after each out_valid&&out_ready. After the last active lane: go to BIAS for group g+1, or to DONE if g==G-1.
  - DONE: pulses `done`; goes to IDLE.
- `tensor_ram_re` and `weight_rom_re` are high only on cycles that issue a read.
- Arithmetic:
  - Each product is int8×int8 sign-extended to ACC_W.
  - acc[k] += product, with two's-complement wrap.
  - Inactive lanes accumulate but are never emitted.
- Requantization, in order:
  1. r = (acc + (shift>0 ? 1<<(shift-1) : 0)) >>> shift, computed at ACC_W+1 bits so the rounding add cannot overflow.
  2. If relu_en, r = max(r, 0).
  3. Saturate r to [-128, 127].
- `start` is ignored while busy. Configuration changes after start have no effect.
- `reset` in any state returns the block to IDLE and clears all counters and accumulators. In-flight memory data is discarded.

## Timing
- Reset values: all addresses 0, all read enables 0, `out_valid` 0, `out_data` 0, `out_idx` 0, `busy` 0, `done` 0.
- `busy` rises the cycle after `start` is accepted. `done` is high for the single DONE cycle; `busy` is low from the cycle after it.
- Per group with `out_ready` held high: 1 (BIAS) + 1 (LOAD) + max(N-1,0) (MAC) + (N>0 ? 1 : 0) (DRAIN) + A (EMIT) cycles, where A is the number of active lanes.
- Layer latency, start to done, is the sum over all groups plus 1.
- Output stream rules:
  - While out_valid && !out_ready, `out_data` and `out_idx` stay stable.
  - `out_valid` never drops without a handshake, except on reset.
  - The accumulators are frozen during EMIT.
- The MAC pipeline does not stall: reads are only issued in LOAD and MAC, and backpressure only affects EMIT.

## Test plan
- LANES=4, N=3, M=4; inputs [1,2,3]; all weights 1; biases [0,10,-10,100]; shift=0; relu off. Required stream: 6, 16, -4, 106 with idx 0..3; done 10 cycles after start.
- Same setup with relu_en=1 and bias[2]=-20. Lane 2 outputs 0, not -14.
- Saturation and rounding: N=1, input 127, weight 127, bias 0. shift=0 gives 127; shift=7 gives 126 (16129+64=16193>>>7=126); input -128 with shift=0 gives -128.
- M=6, LANES=4: 2 groups. Exactly 6 outputs, idx 0..5; lanes 6 and 7 are never emitted. Toggle `out_ready` randomly and check data is held stable under backpressure.
- Edge sizes: N=0 → outputs equal the saturated biases; M=0 → `done` one cycle after busy, with no reads and no outputs.
- Reset asserted mid-MAC, then a fresh start. The second run's results match a golden model, with no state left over from the aborted run.
